// File: rtl/ucode_sequencer.sv
// Microprogram sequencer: two-phase microsteps, wait-state stalls,
// next/end/jump/dispatch sequencing, fault/irq/break/halt entry.
module ucode_sequencer #(
   parameter int          UAW        = 8,
   parameter int          UWW        = 48,
   parameter int          OPW        = 6,
   parameter int          FETCH_BASE = 2,
   parameter int          DISP_BASE  = 0,
   parameter int          IRQ_VEC    = 192,
   parameter int          FAULT_VEC  = 224,
   parameter logic [15:0] HLT_INSTR  = 16'hfe00
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [15:0]    instr,
   output logic [UAW-1:0] uaddr,
   input  logic [UWW-1:0] uword,
   input  logic           mem_rdy,
   input  logic           irq_r,
   input  logic           fault_r,
   input  logic           cont_r,
   output logic [UWW-1:0] ctl,
   output logic           mphase,
   output logic           halted,
   output logic           in_break,
   output logic [15:0]    retired
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_BREAK,
      ST_HALT
   } state_t;

   localparam logic [1:0] SEQ_NEXT = 2'b00;
   localparam logic [1:0] SEQ_END  = 2'b01;
   localparam logic [1:0] SEQ_JUMP = 2'b10;
   localparam logic [1:0] SEQ_DISP = 2'b11;

   localparam logic [UAW-1:0] FETCH_A = UAW'(FETCH_BASE);
   localparam logic [UAW-1:0] DISP_A  = UAW'(DISP_BASE);
   localparam logic [UAW-1:0] IRQ_A   = UAW'(IRQ_VEC);
   localparam logic [UAW-1:0] FAULT_A = UAW'(FAULT_VEC);
   localparam logic [UAW-1:0] ONE     = UAW'(1);

   state_t         state;
   logic [UAW-1:0] upc;
   logic [OPW-1:0] opcode;
   logic [1:0]     seq;
   logic           brk;
   logic           wt;
   logic [UAW-1:0] target;
   logic           hlt_disp;

   assign opcode = instr[15] ? instr[OPW+8:9] : OPW'(instr[14:13]);
   assign seq    = uword[1:0];
   assign brk    = uword[2];
   assign wt     = uword[3];
   assign target = uword[UAW+3:4];
   assign hlt_disp = (seq == SEQ_DISP) && (instr == HLT_INSTR);

   assign uaddr = upc;
   assign ctl   = uword;

   // State advances on the falling edge; outputs settle for the rising edge.
   always_ff @(negedge clk) begin
      if (reset) begin
         state    <= ST_RUN;
         upc      <= FETCH_A;
         mphase   <= 1'b0;
         halted   <= 1'b0;
         in_break <= 1'b0;
         retired  <= '0;
      end else if (state != ST_HALT) begin
         if (fault_r) begin
            state    <= ST_RUN;
            upc      <= FAULT_A;
            mphase   <= 1'b0;
            in_break <= 1'b0;
         end else if (state == ST_BREAK) begin
            if (cont_r) begin
               state    <= ST_RUN;
               upc      <= FETCH_A;
               in_break <= 1'b0;
            end
         end else if (!mphase) begin
            mphase <= 1'b1;
         end else if (hlt_disp) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            mphase <= 1'b0;
         end else if (!(wt && !mem_rdy)) begin
            mphase <= 1'b0;
            unique case (seq)
               SEQ_NEXT: upc <= upc + ONE;
               SEQ_JUMP: upc <= target;
               SEQ_DISP: upc <= DISP_A + UAW'(opcode);
               SEQ_END: begin
                  retired <= retired + 16'd1;
                  if (brk) begin
                     state    <= ST_BREAK;
                     in_break <= 1'b1;
                  end else if (irq_r) begin
                     upc <= IRQ_A;
                  end else begin
                     upc <= FETCH_A;
                  end
               end
               default: upc <= upc;
            endcase
         end
      end
   end

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Parametrised microprogram sequencer for the CPU control unit. It is the successor to the fixed FETCH/DECODE/READ/EXEC phase decoder. Microroutines have variable length, driven by a registered micro-PC with next/end/jump/dispatch sequencing, a memory wait-state stall, and fault/irq/break/halt entry points. The block sits between the instruction register and the external microcode ROM; field decoding of the remaining control bits stays downstream.

## Interface
Parameters:
- UAW, 8, micro-address width.
- UWW, 48, microword width (≥ UAW+4).
- OPW, 6, opcode width.
- FETCH_BASE, 2, micro-address of the fetch routine.
- DISP_BASE, 0, base added to the opcode on dispatch.
- IRQ_VEC, 192, micro-address of the interrupt entry routine.
- FAULT_VEC, 224, micro-address of the fault entry routine.
- HLT_INSTR, 16'hfe00, instruction encoding that halts the sequencer.

Ports:
- clk  in  1  single clock; all state updates on the falling edge of clk.
- reset  in  1  synchronous, active-high.
- instr  in  16  current instruction register.
- uaddr  out  UAW  microword address; equals the micro-PC.
- uword  in  UWW  ROM data for uaddr (combinational ROM).
- mem_rdy  in  1  memory ready; low stalls a wait-flagged microstep.
- irq_r  in  1  registered interrupt request.
- fault_r  in  1  registered fault.
- cont_r  in  1  continue from break.
- ctl  out  UWW  uword passed through; downstream gates load strobes with mphase.
- mphase  out  1  0 = setup half of a microstep, 1 = commit half.
- halted  out  1  sequencer halted.
- in_break  out  1  sequencer in break.
- retired  out  16  count of completed instructions.

## Operation
- Opcode: if instr[15]=0, opcode = zero-extended instr[14:13]; otherwise opcode = instr[OPW+8:9].
- Sequencer fields in the microword:
  - uword[1:0] seq op: 00 NEXT, 01 END, 10 JUMP, 11 DISPATCH.
  - uword[2] brk.
  - uword[3] wait.
  - uword[UAW+3:4] jump target.
- States:
  - RUN: normal execution.
  - BREAK: entered on END with brk=1.
  - HALT: entered on dispatch of HLT_INSTR.
- Each microstep is 2 cycles: mphase 0, then mphase 1. The micro-PC updates only at the end of mphase 1.
- Stall: wait=1 and mem_rdy=0 while mphase=1 → hold mphase=1 and the micro-PC. Stalls may last any number of cycles.
- Next micro-PC at commit:
  - NEXT: upc+1, wrapping mod 2^UAW.
  - JUMP: target.
  - DISPATCH: DISP_BASE+opcode, truncated to UAW bits. If instr==HLT_INSTR, enter HALT instead.
  - END, brk=1: enter BREAK, micro-PC held.
  - END, brk=0, irq_r=1: IRQ_VEC.
  - END otherwise: FETCH_BASE.
- retired increments by 1 on every END commit, wrapping at 16 bits, including END commits that enter BREAK.
- BREAK: mphase=0, in_break=1, ctl still driven. When cont_r=1, go to FETCH_BASE / RUN on the next edge.
- HALT: halted=1, micro-PC held, mphase=0. Only reset exits HALT.
- fault_r=1 on any edge in RUN or BREAK → micro-PC=FAULT_VEC, mphase=0, RUN.
  - Fault overrides stall, END and cont_r.
  - Fault does not increment retired.
  - Fault is ignored in HALT.
- Priority on each edge: reset > fault_r > HLT dispatch > break/cont > stall > sequencing.

## Timing
- Reset values:
  - uaddr=FETCH_BASE, mphase=0.
  - halted=0, in_break=0, retired=0.
  - State=RUN.
- uaddr, mphase, halted, in_break and retired are registered. ctl is combinational from uword.
- Minimum instruction cost = 2×(fetch steps + execute steps) cycles plus stall cycles.
- irq_r is sampled only at END commits. A request asserted mid-routine waits for the next END.
- Reset asserted mid-stall or mid-routine → reset values on the next edge; nothing retires.

## Test plan
- Reset, then a ROM where FETCH_BASE=DISPATCH and opcode 5 routine = NEXT, END, with instr=16'h0005→ wait, instr[15]=0 gives opcode 0; use instr=16'h8A00 (opcode 5).
  - Required uaddr sequence: 2, 5, 6, 2; mphase toggling each cycle.
  - retired=1 after 6 cycles.
- mem_rdy=0 for 3 cycles on a wait=1 step → uaddr and mphase=1 held 3 extra cycles, then sequencing resumes.
- irq_r=1 during the opcode 5 routine → after END, uaddr=192 (not 2); retired still increments.
- END with brk=1 → in_break=1 and uaddr held for 10 cycles. cont_r pulse → uaddr=2, in_break=0.
- instr=16'hfe00 at dispatch → halted=1. Toggle fault_r and cont_r: no change. reset → uaddr=2, halted=0.
- JUMP to 8'hFF, then NEXT → uaddr wraps to 0.
- fault_r=1 during a stall → uaddr=224, mphase=0; retired unchanged.
